// File: rtl/xcr_cdma_engine.sv
// Single-channel memory-to-memory copy engine: one byte per read/write pair
// over a simple req/ack bus, driven by a four-state FSM.
module xcr_cdma_engine #(
  parameter int unsigned ADDR_WID = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cDmaReq,
  input  logic [ADDR_WID-1:0] SrcAddr,
  input  logic [ADDR_WID-1:0] DstAddr,
  input  logic [7:0]          BurstLen,
  output logic                cDmaDone,
  output logic                cDmaBusy,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_WID-1:0] m_adr,
  output logic [7:0]          m_dout,
  input  logic [7:0]          m_din,
  input  logic                m_ack
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  localparam logic [ADDR_WID-1:0] AddrOne = {{(ADDR_WID-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_WID-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_WID-1:0] dst_ptr_q, dst_ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          buf_q, buf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_adr     = '0;
    cDmaDone  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cDmaReq) begin
          src_ptr_d = SrcAddr;
          dst_ptr_d = DstAddr;
          cnt_d     = BurstLen;
          state_d   = (BurstLen != 8'd0) ? StRd : StDone;
        end
      end
      StRd: begin
        m_req = 1'b1;
        m_adr = src_ptr_q;
        if (m_ack) begin
          buf_d   = m_din;
          state_d = StWr;
        end
      end
      StWr: begin
        m_req = 1'b1;
        m_we  = 1'b1;
        m_adr = dst_ptr_q;
        if (m_ack) begin
          // Pointers wrap naturally at ADDR_WID bits.
          src_ptr_d = src_ptr_q + AddrOne;
          dst_ptr_d = dst_ptr_q + AddrOne;
          cnt_d     = cnt_q - 8'd1;
          state_d   = (cnt_q == 8'd1) ? StDone : StRd;
        end
      end
      StDone: begin
        cDmaDone = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cDmaBusy = (state_q != StIdle);
  assign m_dout   = buf_q;

endmodule

// File: tb/tb_xcr_cdma_engine.sv
// Directed bench for xcr_cdma_engine: a bus responder with programmable wait
// states and a scoreboard of expected bus cycles.
module tb_xcr_cdma_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cDmaReq = 1'b0;
  logic [23:0] SrcAddr = '0;
  logic [23:0] DstAddr = '0;
  logic [7:0]  BurstLen = '0;
  logic        cDmaDone, cDmaBusy, m_req, m_we, m_ack;
  logic [23:0] m_adr;
  logic [7:0]  m_dout, m_din;

  xcr_cdma_engine #(.ADDR_WID(24)) dut (
    .clk      (clk),
    .rst      (rst),
    .cDmaReq  (cDmaReq),
    .SrcAddr  (SrcAddr),
    .DstAddr  (DstAddr),
    .BurstLen (BurstLen),
    .cDmaDone (cDmaDone),
    .cDmaBusy (cDmaBusy),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_adr    (m_adr),
    .m_dout   (m_dout),
    .m_din    (m_din),
    .m_ack    (m_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [23:0] adr;
    logic [7:0]  dat;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  wait_cfg = 0;
  int  wait_cnt;
  int  done_cnt = 0;

  function automatic logic [7:0] mem_f(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: ack after wait_cfg wait cycles, read data is a function of address.
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (m_req && !m_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign m_ack = m_req && (wait_cnt == wait_cfg);
  assign m_din = mem_f(m_adr);

  logic        held_vld = 1'b0;
  logic        held_we;
  logic [23:0] held_adr;
  logic [7:0]  held_dout;

  always @(negedge clk) begin
    if (cDmaDone) done_cnt++;
    if (m_req && held_vld) begin
      check("hold_we", {31'd0, m_we}, {31'd0, held_we});
      check("hold_adr", {8'd0, m_adr}, {8'd0, held_adr});
      check("hold_dout", {24'd0, m_dout}, {24'd0, held_dout});
    end
    if (m_req && !m_ack) begin
      held_vld  = 1'b1;
      held_we   = m_we;
      held_adr  = m_adr;
      held_dout = m_dout;
    end else begin
      held_vld = 1'b0;
    end
    if (m_req && m_ack) begin
      if (exp_q.size() == 0) begin
        check("bus_unexpected", 32'd1, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("bus_we", {31'd0, m_we}, {31'd0, e.we});
        check("bus_adr", {8'd0, m_adr}, {8'd0, e.adr});
        if (e.we) check("bus_wdata", {24'd0, m_dout}, {24'd0, e.dat});
      end
    end
  end

  task automatic push_xfer(input logic [23:0] src, input logic [23:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      logic [23:0] s, d;
      s = src + 24'(i);
      d = dst + 24'(i);
      exp_q.push_back('{we: 1'b0, adr: s, dat: 8'h00});
      exp_q.push_back('{we: 1'b1, adr: d, dat: mem_f(s)});
    end
  endtask

  // Called #1 after the edge that left IDLE (cycle 1).
  task automatic wait_done(input string tag, input int exp_cyc);
    int n;
    n = 1;
    while (cDmaDone !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, exp_cyc);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, cDmaDone}, 32'd0);
    check("idle_not_busy", {31'd0, cDmaBusy}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic run(input string tag, input logic [23:0] src, input logic [23:0] dst,
                     input int len, input int waits, input int exp_cyc);
    wait_cfg = waits;
    push_xfer(src, dst, len);
    @(negedge clk);
    SrcAddr  = src;
    DstAddr  = dst;
    BurstLen = 8'(len);
    cDmaReq  = 1'b1;
    @(posedge clk); #1;
    cDmaReq = 1'b0;
    check("busy_after_req", {31'd0, cDmaBusy}, 32'd1);
    wait_done(tag, exp_cyc);
  endtask

  initial begin
    int dsnap;
    #2;
    check("rst_busy", {31'd0, cDmaBusy}, 32'd0);
    check("rst_done", {31'd0, cDmaDone}, 32'd0);
    check("rst_req", {31'd0, m_req}, 32'd0);
    check("rst_we", {31'd0, m_we}, 32'd0);
    check("rst_adr", {8'd0, m_adr}, 32'd0);
    check("rst_dout", {24'd0, m_dout}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    run("basic_done_cyc", 24'h000100, 24'h000200, 4, 0, 9);
    run("len0_done_cyc", 24'h000300, 24'h000400, 0, 0, 1);
    run("wrap_done_cyc", 24'hFFFFFF, 24'hFFFFFE, 3, 0, 7);
    run("wait_done_cyc", 24'h001234, 24'h005678, 2, 3, 17);

    // Reset during the second write of a 5-byte transfer.
    wait_cfg = 0;
    push_xfer(24'h000010, 24'h000080, 5);
    @(negedge clk);
    SrcAddr = 24'h000010; DstAddr = 24'h000080; BurstLen = 8'd5; cDmaReq = 1'b1;
    @(posedge clk); #1;
    cDmaReq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_we", {31'd0, m_we}, 32'd1);
    check("pre_rst_adr", {8'd0, m_adr}, 32'h000081);
    dsnap = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_req", {31'd0, m_req}, 32'd0);
    check("mid_rst_busy", {31'd0, cDmaBusy}, 32'd0);
    check("mid_rst_adr", {8'd0, m_adr}, 32'd0);
    check("mid_rst_dout", {24'd0, m_dout}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt, dsnap);
    run("post_rst_done_cyc", 24'h000020, 24'h000090, 5, 0, 11);

    // cDmaReq held high; SrcAddr changed mid-transfer applies only to the next one.
    push_xfer(24'h000500, 24'h000600, 1);
    push_xfer(24'h000700, 24'h000600, 1);
    @(negedge clk);
    SrcAddr = 24'h000500; DstAddr = 24'h000600; BurstLen = 8'd1; cDmaReq = 1'b1;
    @(posedge clk); #1;
    SrcAddr = 24'h000700;
    check("held_rd_adr", {8'd0, m_adr}, 32'h000500);
    repeat (2) @(posedge clk);
    #1;
    check("held_first_done", {31'd0, cDmaDone}, 32'd1);
    @(posedge clk); #1;
    check("held_idle_gap", {31'd0, cDmaBusy}, 32'd0);
    @(posedge clk); #1;
    cDmaReq = 1'b0;
    check("held_restart_req", {31'd0, m_req}, 32'd1);
    check("held_restart_adr", {8'd0, m_adr}, 32'h000700);
    wait_done("held_second_done_cyc", 3);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xcr_cdma_engine.md
XCR_CDMA_ENGINE -- requirements
Module: xcr_cdma_engine

Interface
REQ-001 The module SHALL have parameter ADDR_WID, default 24, the width of the byte address.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cDmaReq  input  1  level transfer request from the cDMA control registers.
REQ-005 SrcAddr  input  ADDR_WID  first source byte address.
REQ-006 DstAddr  input  ADDR_WID  first destination byte address.
REQ-007 BurstLen  input  8  number of bytes to copy, 0..255.
REQ-008 cDmaDone  output  1  one-cycle completion pulse.
REQ-009 cDmaBusy  output  1  high while a transfer is in progress.
REQ-010 m_req  output  1  memory-bus cycle request.
REQ-011 m_we  output  1  memory-bus write strobe: 1 = write, 0 = read.
REQ-012 m_adr  output  ADDR_WID  memory-bus byte address.
REQ-013 m_dout  output  8  memory-bus write data.
REQ-014 m_din  input  8  memory-bus read data, valid when m_ack=1 during a read.
REQ-015 m_ack  input  1  memory-bus completion; may be asserted in the same cycle as m_req or any number of cycles later.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RD, WR and DONE.
REQ-017 IDLE with cDmaReq=1: latch SrcAddr into src_ptr, DstAddr into dst_ptr and BurstLen into cnt; go to RD if BurstLen!=0, else go to DONE.
REQ-018 IDLE with cDmaReq=0: remain in IDLE.
REQ-019 Changes to SrcAddr, DstAddr or BurstLen after the latch cycle SHALL have no effect on the running transfer.
REQ-020 RD: m_req=1, m_we=0, m_adr=src_ptr; hold these until m_ack=1.
REQ-021 RD with m_ack=1: capture m_din into an 8-bit data buffer and go to WR.
REQ-022 WR: m_req=1, m_we=1, m_adr=dst_ptr, m_dout=buffer; hold these until m_ack=1.
REQ-023 WR with m_ack=1: increment src_ptr and dst_ptr, and decrement cnt.
REQ-024 WR with m_ack=1: go to DONE if cnt was 1 before the decrement, else go to RD.
REQ-025 Pointer increments SHALL wrap modulo 2^ADDR_WID, e.g. all-ones + 1 = 0.
REQ-026 DONE: cDmaDone=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-027 cDmaBusy SHALL be 1 in RD, WR and DONE, and 0 in IDLE.
REQ-028 m_req SHALL be 0 in IDLE and DONE; m_ack SHALL be ignored in those states.
REQ-029 cDmaReq is level-sensitive and sampled only in IDLE; a requester that keeps it high after the cDmaDone pulse SHALL start a new transfer.
REQ-030 m_adr, m_dout and m_we SHALL be stable whenever m_req=1 and m_ack=0.
REQ-031 Timing with zero-wait ack: cDmaReq sampled in IDLE at cycle 0 gives RD at cycle 1 and cDmaDone at cycle 2N+1 for BurstLen=N.
REQ-032 Timing with BurstLen=0: cDmaDone at cycle 1, with no bus cycle issued.
REQ-033 Each wait cycle (m_req=1, m_ack=0) SHALL extend the transfer by exactly one cycle.

Reset
REQ-034 While rst=1, state SHALL be IDLE, with cDmaDone=0, cDmaBusy=0, m_req=0 and m_we=0.
REQ-035 While rst=1, m_adr, m_dout, src_ptr, dst_ptr, cnt and the data buffer SHALL be 0.
REQ-036 Asserting rst mid-transfer SHALL drop m_req immediately (asynchronously), abandon the transfer and produce no cDmaDone pulse.

Verification
REQ-037 Scenario: SrcAddr=0x000100, DstAddr=0x000200, BurstLen=4, zero-wait memory -> 4 reads at 0x100..0x103, then writes at 0x200..0x203 with matching data, interleaved R/W; cDmaDone pulses at cycle 9.
REQ-038 Scenario: BurstLen=0 -> no m_req; cDmaDone=1 at cycle 1 for one cycle; cDmaBusy high for that one cycle only.
REQ-039 Scenario: SrcAddr=0xFFFFFF, DstAddr=0xFFFFFE, BurstLen=3 -> read addresses 0xFFFFFF, 0x000000, 0x000001; write addresses 0xFFFFFE, 0xFFFFFF, 0x000000.
REQ-040 Scenario: BurstLen=2 with m_ack delayed 3 cycles on every access -> address and data held stable during waits; cDmaDone at cycle 5+4*3=17.
REQ-041 Scenario: rst asserted during the second WR of a BurstLen=5 transfer -> m_req=0 in the same cycle, no cDmaDone; after release a new cDmaReq runs a full transfer correctly.
REQ-042 Scenario: cDmaReq held high through cDmaDone with BurstLen=1 -> the second transfer starts in the cycle after DONE; SrcAddr changed mid-transfer does not alter the current addresses.
